squeeze_weight_fetch: RTL and testbench
=======================================

Name: squeeze_weight_fetch

Overview:
Read-side sequencer for the squeeze-layer weight store, which holds 1x1 squeeze weights and biases for fires 1-8. For one fire it issues the fire select, 8 per-filter weight addresses and 8 filter (bias) indices. It walks filters in groups of 8 and input channels in chunks of 16. It registers the returned 8x16 weight vectors and 8 biases, then streams them one beat per chunk to the squeeze MAC array over a valid/ready handshake.

Parameters:
ADDR_W, 32, width of each weight address and filter index (matches store address ports)
DATA_W, 16, width of one weight or bias word
NPAR_C, 16, channels per beat; fixed by the store's 16-word read window
NPAR_F, 8, filters per beat; fixed by the store's 8 read ports

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to fetch the fire given on fire_in
fire_in  in  3  fire number minus 1 (0 = fire 1 ... 7 = fire 8)
busy  out  1  high from accepted start until the done pulse
done  out  1  one-cycle pulse after the last beat is accepted
firesel  out  3  fire select to the weight store
waddr  out  NPAR_F*ADDR_W  slot k (bits k*ADDR_W +: ADDR_W) gives the first-channel address for filter slot k
faddr  out  NPAR_F*ADDR_W  slot k gives the filter index for bias lookup
wdata  in  NPAR_F*NPAR_C*DATA_W  weights returned by the store, combinational from waddr
bdata  in  NPAR_F*DATA_W  biases returned by the store, combinational from faddr
out_wvec  out  NPAR_F*NPAR_C*DATA_W  registered weight beat
out_bias  out  NPAR_F*DATA_W  registered biases for the current filter group
out_fgrp  out  4  filter-group index of the beat
out_chunk  out  6  channel-chunk index of the beat
out_last_chunk  out  1  beat is the final chunk of its filter group
out_last  out  1  beat is the final beat of the fire
out_vld  out  1  beat valid
out_rdy  in  1  consumer accepts the beat when out_vld and out_rdy are both high

Behaviour:
- Reset value of every output and internal register is 0. State goes to IDLE. Reset mid-fetch aborts immediately; no done pulse is generated.
- Per-fire geometry table, NF/CIN:
  - fire 1: 16/64
  - fire 2: 16/128
  - fire 3: 32/128
  - fire 4: 32/256
  - fire 5: 48/256
  - fire 6: 48/384
  - fire 7: 64/384
  - fire 8: 64/512
- Derived counts: NG = NF/8 groups, NC = CIN/16 chunks. Beats per fire = NG*NC.
- Address formulas, with f = g*8+k for group g, chunk c, slot k:
  - waddr slot k = f*CIN + c*16
  - faddr slot k = f
  - Computed in ADDR_W-bit unsigned arithmetic from registered g and c counters, using shift/add (CIN and 16 are multiples of 16).
- Store timing:
  - firesel, waddr and faddr are registered.
  - The store responds combinationally in the same cycle.
  - The fetcher captures wdata and bdata into the out_* registers on the next edge.
- States:
  - IDLE: start=1 latches fire_in into firesel, clears g and c, sets busy=1, goes to ADDR. start is ignored when not in IDLE.
  - ADDR: addresses for (g,c) are stable for one cycle. Goes to EMIT.
  - EMIT: capture wdata/bdata into the out registers. Set out_vld=1, out_fgrp=g, out_chunk=c, out_last_chunk=(c==NC-1), out_last=(g==NG-1 && c==NC-1). Advance c, wrapping to 0 and incrementing g. Goes to HOLD.
  - HOLD: wait until out_vld && out_rdy, then clear out_vld. If the accepted beat had out_last, go to DONE; otherwise go to ADDR.
  - DONE: done=1 for one cycle, busy=0 on the following cycle, goes to IDLE.
- Latency and throughput:
  - start accepted at edge 0, first out_vld at edge 2.
  - One beat per 3 cycles with out_rdy held high.
- Handshake rules:
  - out_* are stable while out_vld=1 and out_rdy=0.
  - out_vld never drops without acceptance, except on reset.
- out_bias is refreshed every beat and is constant across the chunks of a group.
- The fetcher emits no wrap or overrun beat after out_last.

Test Plan:
- Fire 1 (fire_in=0), out_rdy=1 throughout -> exactly 8 beats.
  - Beat 0: waddr slot0=0, slot7=448, faddr slot7=7.
  - Beat 1: slot0=16, out_chunk=1.
  - Beat 4: out_fgrp=1, waddr slot0=512, faddr slot0=8.
  - Beat 7: out_last=1.
  - done pulses once and busy falls.
- Fire 8 (fire_in=7) -> 256 beats.
  - Final beat: waddr slot7=63*512+496=32752, faddr slot7=63, out_chunk=31, out_fgrp=7.
  - Beat count checked.
- Backpressure: out_rdy=0 for 5 cycles on beat 2 of fire 3 -> out_vld and all out_* held bit-stable. waddr does not advance. The beat completes on out_rdy=1 and none are lost or duplicated.
- start pulsed with fire_in=5 while busy on fire 2 -> ignored; firesel stays 1 and the fire-2 beat count is 16.
- Reset asserted asynchronously mid-EMIT of fire 4 -> all outputs 0 immediately, no done. A new start on fire 1 then runs the standard 8 beats correctly.
- Data path: the store model returns wdata/bdata as a function of address -> every out_wvec/out_bias matches the model for its (fgrp, chunk) across all 8 fires.

Source files
------------

// File: rtl/squeeze_weight_fetch.sv
// Squeeze-layer weight fetcher: walks filter groups of 8 and channel chunks of 16
// for one fire, drives the weight-store addresses, captures the returned weights
// and biases, and streams them one beat per chunk over a valid/ready handshake.
module squeeze_weight_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int NPAR_C = 16,
  parameter int NPAR_F = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       fire_in,
  output logic                             busy,
  output logic                             done,
  output logic [2:0]                       firesel,
  output logic [NPAR_F*ADDR_W-1:0]         waddr,
  output logic [NPAR_F*ADDR_W-1:0]         faddr,
  input  logic [NPAR_F*NPAR_C*DATA_W-1:0]  wdata,
  input  logic [NPAR_F*DATA_W-1:0]         bdata,
  output logic [NPAR_F*NPAR_C*DATA_W-1:0]  out_wvec,
  output logic [NPAR_F*DATA_W-1:0]         out_bias,
  output logic [3:0]                       out_fgrp,
  output logic [5:0]                       out_chunk,
  output logic                             out_last_chunk,
  output logic                             out_last,
  output logic                             out_vld,
  input  logic                             out_rdy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    EMIT,
    HOLD,
    DONE
  } state_t;

  state_t      state;
  logic [3:0]  g;
  logic [5:0]  c;
  logic [3:0]  ng_last;
  logic [5:0]  nc_last;

  logic [NPAR_F*ADDR_W-1:0] waddr_calc;
  logic [NPAR_F*ADDR_W-1:0] faddr_calc;

  // f * CIN for the selected fire; every CIN is 64 times {1,2,4,6,8}, so a
  // couple of shifts and one add cover the whole table.
  function automatic logic [ADDR_W-1:0] scale_cin(input logic [ADDR_W-1:0] f,
                                                   input logic [2:0] fire);
    logic [ADDR_W-1:0] r;
    case (fire)
      3'd0:          r = f << 6;
      3'd1, 3'd2:    r = f << 7;
      3'd3, 3'd4:    r = f << 8;
      3'd5, 3'd6:    r = (f << 8) + (f << 7);
      default:       r = f << 9;
    endcase
    return r;
  endfunction

  // Last group / last chunk index for the latched fire (NG-1, NC-1).
  always_comb begin
    ng_last = 4'd1;
    nc_last = 6'd3;
    case (firesel)
      3'd0: begin ng_last = 4'd1; nc_last = 6'd3;  end
      3'd1: begin ng_last = 4'd1; nc_last = 6'd7;  end
      3'd2: begin ng_last = 4'd3; nc_last = 6'd7;  end
      3'd3: begin ng_last = 4'd3; nc_last = 6'd15; end
      3'd4: begin ng_last = 4'd5; nc_last = 6'd15; end
      3'd5: begin ng_last = 4'd5; nc_last = 6'd23; end
      3'd6: begin ng_last = 4'd7; nc_last = 6'd23; end
      default: begin ng_last = 4'd7; nc_last = 6'd31; end
    endcase
  end

  // Per-slot address generation: filter f = g*8 + k.
  genvar gi;
  generate
    for (gi = 0; gi < NPAR_F; gi++) begin : g_slot
      logic [ADDR_W-1:0] f;
      assign f = (ADDR_W'(g) << 3) + ADDR_W'(gi);
      assign waddr_calc[gi*ADDR_W +: ADDR_W] = scale_cin(f, firesel) + (ADDR_W'(c) << 4);
      assign faddr_calc[gi*ADDR_W +: ADDR_W] = f;
    end
  endgenerate

  // Sequencer: address, capture, hold for handshake, finish with a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      g              <= '0;
      c              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      firesel        <= '0;
      waddr          <= '0;
      faddr          <= '0;
      out_wvec       <= '0;
      out_bias       <= '0;
      out_fgrp       <= '0;
      out_chunk      <= '0;
      out_last_chunk <= 1'b0;
      out_last       <= 1'b0;
      out_vld        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            firesel <= fire_in;
            g       <= '0;
            c       <= '0;
            busy    <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          waddr <= waddr_calc;
          faddr <= faddr_calc;
          state <= EMIT;
        end
        EMIT: begin
          out_wvec       <= wdata;
          out_bias       <= bdata;
          out_vld        <= 1'b1;
          out_fgrp       <= g;
          out_chunk      <= c;
          out_last_chunk <= (c == nc_last);
          out_last       <= (c == nc_last) && (g == ng_last);
          if (c == nc_last) begin
            c <= '0;
            g <= g + 4'd1;
          end else begin
            c <= c + 6'd1;
          end
          state <= HOLD;
        end
        HOLD: begin
          if (out_vld && out_rdy) begin
            out_vld <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= ADDR;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_weight_fetch.sv
// Bench for squeeze_weight_fetch: a weight-store model answers from the
// addresses, expected beats are queued at stimulus time and a monitor pops and
// compares each accepted beat.
module tb_squeeze_weight_fetch;

  localparam int AW = 8 * 32;
  localparam int WW = 8 * 16 * 16;
  localparam int BW = 8 * 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [2:0]    fire_in;
  logic          busy;
  logic          done;
  logic [2:0]    firesel;
  logic [AW-1:0] waddr;
  logic [AW-1:0] faddr;
  logic [WW-1:0] wdata_s;
  logic [BW-1:0] bdata_s;
  logic [WW-1:0] out_wvec;
  logic [BW-1:0] out_bias;
  logic [3:0]    out_fgrp;
  logic [5:0]    out_chunk;
  logic          out_last_chunk;
  logic          out_last;
  logic          out_vld;
  logic          out_rdy;

  squeeze_weight_fetch dut (
    .clk(clk), .rst(rst), .start(start), .fire_in(fire_in),
    .busy(busy), .done(done), .firesel(firesel),
    .waddr(waddr), .faddr(faddr), .wdata(wdata_s), .bdata(bdata_s),
    .out_wvec(out_wvec), .out_bias(out_bias), .out_fgrp(out_fgrp),
    .out_chunk(out_chunk), .out_last_chunk(out_last_chunk),
    .out_last(out_last), .out_vld(out_vld), .out_rdy(out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    fgrp;
    logic [5:0]    chunk;
    logic          lc;
    logic          l;
    logic [31:0]   w0;
    logic [31:0]   w7;
    logic [31:0]   f0;
    logic [31:0]   f7;
    logic [WW-1:0] wvec;
    logic [BW-1:0] bias;
  } beat_t;

  beat_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int run_beats = 0;
  int done_cnt = 0;
  int stall_beat = -1;
  int stall_left = 0;

  // logged fields of the first 8 beats of the latest run, plus its last beat
  logic [31:0] log_w0 [8];
  logic [31:0] log_w7 [8];
  logic [31:0] log_f0 [8];
  logic [31:0] log_f7 [8];
  logic [5:0]  log_chunk [8];
  logic [3:0]  log_fgrp [8];
  logic        log_last [8];
  logic [31:0] last_w7;
  logic [31:0] last_f7;
  logic [5:0]  last_chunk;
  logic [3:0]  last_fgrp;

  function automatic logic [15:0] mw(input logic [31:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] mb(input logic [31:0] f);
    return 16'(f * 257 + 3);
  endfunction

  // Weight store model: combinational from the addresses.
  always_comb begin
    wdata_s = '0;
    bdata_s = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 16; j++)
        wdata_s[(k*16+j)*16 +: 16] = mw(waddr[k*32 +: 32] + 32'(j));
      bdata_s[k*16 +: 16] = mb(faddr[k*32 +: 32]);
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_wvec(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    int idx;
    tests++;
    if (act !== req) begin
      fails++;
      idx = 0;
      for (int i = 127; i >= 0; i--)
        if (act[i*16 +: 16] !== req[i*16 +: 16]) idx = i;
      $display("FAIL %s: word %0d got %0h, required %0h", name, idx,
               act[idx*16 +: 16], req[idx*16 +: 16]);
    end
  endtask

  // Queue every expected beat of a fire; returns the beat count.
  function automatic int push_fire(input int fire);
    int nf_t [8] = '{16, 16, 32, 32, 48, 48, 64, 64};
    int cin_t [8] = '{64, 128, 128, 256, 256, 384, 384, 512};
    int ng, nc, cin, addr, n;
    beat_t e;
    cin = cin_t[fire];
    ng  = nf_t[fire] / 8;
    nc  = cin / 16;
    n   = 0;
    for (int g = 0; g < ng; g++) begin
      for (int c = 0; c < nc; c++) begin
        e.fgrp  = 4'(g);
        e.chunk = 6'(c);
        e.lc    = (c == nc - 1);
        e.l     = (c == nc - 1) && (g == ng - 1);
        e.f0    = 32'(g * 8);
        e.f7    = 32'(g * 8 + 7);
        e.wvec  = '0;
        e.bias  = '0;
        e.w0    = '0;
        e.w7    = '0;
        for (int k = 0; k < 8; k++) begin
          addr = (g * 8 + k) * cin + c * 16;
          if (k == 0) e.w0 = 32'(addr);
          if (k == 7) e.w7 = 32'(addr);
          for (int j = 0; j < 16; j++)
            e.wvec[(k*16+j)*16 +: 16] = mw(32'(addr + j));
          e.bias[k*16 +: 16] = mb(32'(g * 8 + k));
        end
        exp_q.push_back(e);
        n++;
      end
    end
    return n;
  endfunction

  // Consumer ready: high except for a programmed stall on one beat index.
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && out_vld && run_beats == stall_beat) begin
        out_rdy = 1'b0;
        stall_left--;
      end else begin
        out_rdy = 1'b1;
      end
    end
  end

  // Monitor: stall stability, accepted-beat scoreboard, done counting.
  initial begin
    beat_t e;
    bit stall_seen;
    logic [11:0]   s_ctl;
    logic [AW-1:0] s_waddr;
    logic [BW-1:0] s_bias;
    logic [WW-1:0] s_wvec;
    stall_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_seen = 0;
      end else begin
        if (stall_seen) begin
          check("hold_vld", out_vld, 1'b1);
          check("hold_ctl", {out_fgrp, out_chunk, out_last_chunk, out_last}, s_ctl);
          check("hold_waddr", waddr, s_waddr);
          check("hold_bias", out_bias, s_bias);
          check_wvec("hold_wvec", out_wvec, s_wvec);
        end
        stall_seen = out_vld && !out_rdy;
        s_ctl   = {out_fgrp, out_chunk, out_last_chunk, out_last};
        s_waddr = waddr;
        s_bias  = out_bias;
        s_wvec  = out_wvec;
        if (out_vld && out_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("fgrp", out_fgrp, e.fgrp);
            check("chunk", out_chunk, e.chunk);
            check("last_chunk", out_last_chunk, e.lc);
            check("last", out_last, e.l);
            check("waddr0", waddr[31:0], e.w0);
            check("waddr7", waddr[255:224], e.w7);
            check("faddr0", faddr[31:0], e.f0);
            check("faddr7", faddr[255:224], e.f7);
            check("bias", out_bias, e.bias);
            check_wvec("wvec", out_wvec, e.wvec);
          end
          if (run_beats < 8) begin
            log_w0[run_beats]    = waddr[31:0];
            log_w7[run_beats]    = waddr[255:224];
            log_f0[run_beats]    = faddr[31:0];
            log_f7[run_beats]    = faddr[255:224];
            log_chunk[run_beats] = out_chunk;
            log_fgrp[run_beats]  = out_fgrp;
            log_last[run_beats]  = out_last;
          end
          last_w7    = waddr[255:224];
          last_f7    = faddr[255:224];
          last_chunk = out_chunk;
          last_fgrp  = out_fgrp;
          $display("[TB] beat %0d fgrp=%0d chunk=%0d last=%0b waddr0=%0d", run_beats,
                   out_fgrp, out_chunk, out_last, waddr[31:0]);
          run_beats++;
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, firesel, out_fgrp, out_chunk,
                          out_last_chunk, out_last, out_vld}, '0);
    check({tag, "_waddr"}, waddr, '0);
    check({tag, "_faddr"}, faddr, '0);
    check({tag, "_bias"}, out_bias, '0);
    check_wvec({tag, "_wvec"}, out_wvec, '0);
  endtask

  task automatic pulse_start(input logic [2:0] f);
    @(posedge clk);
    #1 start = 1'b1;
    fire_in = f;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_fire(input int fire, input bit inject);
    int nb, budget, d0;
    bit got;
    exp_q.delete();
    nb = push_fire(fire);
    run_beats = 0;
    d0 = done_cnt;
    pulse_start(3'(fire));
    check("busy_rise", busy, 1'b1);
    if (inject) begin
      repeat (10) @(posedge clk);
      pulse_start(3'd5);
      check("firesel_hold", firesel, 3'(fire));
    end
    budget = nb * 3 + 60;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
    @(negedge clk);
    check("busy_fall", busy, 1'b0);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("beat_count", 32'(run_beats), 32'(nb));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] fire %0d finished: %0d beats", fire + 1, run_beats);
    exp_q.delete();
  endtask

  task automatic spot_fire1();
    check("f1_b0_w0", log_w0[0], 32'd0);
    check("f1_b0_w7", log_w7[0], 32'd448);
    check("f1_b0_f7", log_f7[0], 32'd7);
    check("f1_b1_w0", log_w0[1], 32'd16);
    check("f1_b1_chunk", log_chunk[1], 6'd1);
    check("f1_b4_fgrp", log_fgrp[4], 4'd1);
    check("f1_b4_w0", log_w0[4], 32'd512);
    check("f1_b4_f0", log_f0[4], 32'd8);
    check("f1_b7_last", log_last[7], 1'b1);
  endtask

  initial begin
    int d0;
    bit got;
    rst = 1'b1;
    start = 1'b0;
    fire_in = 3'd0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    // fire 1 with ready held high
    run_fire(0, 0);
    spot_fire1();

    // fire 8: 256 beats, final-beat addresses
    run_fire(7, 0);
    check("f8_last_w7", last_w7, 32'd32752);
    check("f8_last_f7", last_f7, 32'd63);
    check("f8_last_chunk", last_chunk, 6'd31);
    check("f8_last_fgrp", last_fgrp, 4'd7);

    // fire 3 with a 5-cycle stall on beat 2
    stall_beat = 2;
    stall_left = 5;
    run_fire(2, 0);
    check("stall_consumed", 32'(stall_left), 32'd0);
    stall_beat = -1;

    // start while busy on fire 2 is ignored
    run_fire(1, 1);

    // asynchronous reset in the EMIT cycle of fire 4
    exp_q.delete();
    void'(push_fire(3));
    run_beats = 0;
    d0 = done_cnt;
    pulse_start(3'd3);
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (run_beats == 3) begin
        got = 1;
        break;
      end
    end
    check("rst_reach_beat3", got, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("no_done_on_rst", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    check("idle_after_rst", {busy, out_vld}, 2'b00);

    // fresh fire 1 after the abort
    run_fire(0, 0);
    spot_fire1();

    // data path across all fires
    for (int f = 0; f < 8; f++) run_fire(f, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
